// File: rtl/logic_unit_arbiter.sv
// Shares one 4-bit bitwise logic unit between NUM_REQ requesters.
// Define LOGIC_ARB_FIXED_PRIO_EN for fixed (lowest index wins) priority.
module logic_unit_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [4*NUM_REQ-1:0] req_a,
  input  logic [4*NUM_REQ-1:0] req_b,
  input  logic [2*NUM_REQ-1:0] req_func,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [3:0]           rsp_data,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t state, state_nxt;

  logic [ID_W-1:0]    gnt_id;
  logic               gnt_any;
  logic [NUM_REQ-1:0] gnt_oh;
  logic               hs;

  logic [3:0]      op_a;
  logic [3:0]      op_b;
  logic [1:0]      op_func;
  logic [ID_W-1:0] op_id;

`ifndef LOGIC_ARB_FIXED_PRIO_EN
  logic [ID_W-1:0] rr_ptr;
`endif

  function automatic logic [3:0] lu(
    input logic [3:0] a,
    input logic [3:0] b,
    input logic [1:0] f
  );
    logic [3:0] r;
    r = '0;
    unique case (f)
      2'b00: r = a & b;
      2'b01: r = a | b;
      2'b10: r = a ^ b;
      2'b11: r = a ~^ b;
    endcase
    return r;
  endfunction

  // First valid requester in search order
  always_comb begin : arb
    logic [ID_W-1:0] cand;
    gnt_any = 1'b0;
    gnt_id  = '0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef LOGIC_ARB_FIXED_PRIO_EN
      cand = ID_W'(k);
`else
      cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
`endif
      if (!gnt_any && req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_id  = cand;
      end
    end
  end

  assign gnt_oh = gnt_any ? (NUM_REQ'(1) << gnt_id) : '0;

  assign req_ready = (rst_n && state == IDLE) ? gnt_oh : '0;
  assign hs        = |(req_ready & req_valid);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (hs) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_a      <= '0;
      op_b      <= '0;
      op_func   <= '0;
      op_id     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
`ifndef LOGIC_ARB_FIXED_PRIO_EN
      rr_ptr    <= '0;
`endif
    end else begin
      if (hs) begin
        op_a    <= req_a[{gnt_id, 2'b00} +: 4];
        op_b    <= req_b[{gnt_id, 2'b00} +: 4];
        op_func <= req_func[{gnt_id, 1'b0} +: 2];
        op_id   <= gnt_id;
`ifndef LOGIC_ARB_FIXED_PRIO_EN
        rr_ptr  <= (gnt_id == ID_W'(NUM_REQ - 1))
                   ? '0 : gnt_id + ID_W'(1);
`endif
      end
      if (state == EXEC) begin
        rsp_data  <= lu(op_a, op_b, op_func);
        rsp_id    <= op_id;
        rsp_valid <= 1'b1;
      end else if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule
